score_display_sequencer: RTL and testbench
==========================================

Name: score_display_sequencer

Overview:
Keeps the memory game's hit and miss tallies and computes the success percentage with a sequential divider. Converts all three values to decimal digits with sequential double-dabble, then drives the six seven-segment digits from a selectable display page. It sits between the game FSM (guess events, new-game clear) and the board HEX5..HEX0 pins. All state is single-clock; there are no event-edge-clocked counters.

Parameters:
- SAT_MAX, 99: saturation limit for the hit and miss counters. Must be ≤ 99 so each fits two decimal digits.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous new-game clear, 1-cycle pulse
- guess_valid  in  1  guess event; accepted only when guess_valid & ready
- guess_hit  in  1  qualifies guess_valid: 1 = correct, 0 = incorrect
- ready  out  1  high in IDLE; low while a score update is computing
- page_sel  in  2  display page: 0 hits, 1 misses, 2 percent, 3 summary
- hex5..hex0  out  7 each  segment drive, active-low, bit6=g … bit0=a

Behaviour:
Reset (async, resetn=0):
- hits=0, misses=0, pct=0; all digit registers 0.
- FSM = IDLE, ready=1.
- Display registers load page-0 content. hex5 = 7'b1000110 ("C"), hex4..hex2 = blank 7'b1111111, hex1 = hex0 = 7'b1000000 ("0").

FSM states: IDLE -> UPDATE -> DIVIDE -> CONVERT -> LOAD -> IDLE.
- IDLE: ready=1. On guess_valid, go to UPDATE. If guess_hit=1, hits=min(hits+1,SAT_MAX); otherwise misses=min(misses+1,SAT_MAX).
- UPDATE (1 cycle): latch numerator = 100*hits (14 bit) and denominator = hits+misses (8 bit).
- DIVIDE (14 cycles): restoring division, one quotient bit per cycle, MSB first. pct = floor(100*hits/(hits+misses)), 7 bit, range 0..100. If the denominator is 0, pct=0 and the divider still runs the full 14 cycles (fixed latency).
- CONVERT (7 cycles): three parallel double-dabble shifters on the 7-bit values hits, misses and pct. Produces tens/ones digits for hits and misses, and hundreds/tens/ones digits for pct.
- LOAD (1 cycle): copy the BCD results into the shadow digit registers, then return to IDLE.
- Latency: with the accept edge at cycle 0, the new digits and ready=1 appear after edge 23. The display holds the previous snapshot until then; no partial values are ever shown.
- guess_valid while ready=0 is ignored: not counted, not queued.

clear:
- Highest priority, in any state: counters, pct and shadow digits go to 0, FSM goes to IDLE, ready=1 on the next edge.
- If clear and guess_valid arrive in the same cycle, the guess is dropped.

Display: registered outputs, 1-cycle latency from a page_sel change. Fields are listed hex5..hex0.
- page 0: "C", blank, blank, blank, hits tens, hits ones. Leading zero shown.
- page 1: "E" (7'b0000110), blank, blank, blank, misses tens, misses ones.
- page 2: "P" (7'b0001100), blank, blank, pct hundreds, pct tens, pct ones. Leading zeros blanked except the ones digit.
- page 3: hits(2 digits), misses(2 digits), pct tens/ones. pct=100 shows "99". Leading zeros shown.

Counters saturate at SAT_MAX and never wrap. At saturation, a further guess still runs the full sequence with unchanged values.

Decomposition:
- Package memory_game_pkg holds:
  - seven-segment constants: SEG_0..SEG_9, SEG_C, SEG_E, SEG_P, SEG_BLANK;
  - page encodings PAGE_HITS, PAGE_MISS, PAGE_PCT, PAGE_SUM;
  - FSM state encoding;
  - cycle constants DIV_CYCLES=14 and BCD_CYCLES=7.
- Sub-module score_divider: iterative restoring divider with start/done and a 14-bit/8-bit interface. Double-dabble and segment decode stay inline.

Test Plan:
- Reset, then page_sel=0 -> hex5..0 = C, blank×3, 0, 0; ready=1.
- 3 hits + 1 miss, page 2 -> blank, 7, 5 on hex2..0. Each guess drops ready for exactly 23 cycles. Display changes only after edge 23.
- 1 hit + 2 misses -> pct 33 (floor). 5 hits only -> pct shows 1,0,0. Page 3 with 5 hits only -> 0,5,0,0,9,9.
- 101 hits -> page 0 shows 9,9; no wrap. pct=100.
- guess_valid pulses during busy cycles 5 and 20 -> counts unchanged by them.
- clear at DIVIDE cycle 8 and clear+guess in the same cycle -> all zeros, ready=1 next edge, no count. Async resetn mid-CONVERT -> immediate reset values.

Source files
------------

// File: rtl/memory_game_pkg.sv
// Shared constants, types and helpers for the memory game score display.
package memory_game_pkg;

  // Active-low segments, bit6 = g ... bit0 = a.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] PAGE_HITS = 2'd0;
  localparam logic [1:0] PAGE_MISS = 2'd1;
  localparam logic [1:0] PAGE_PCT  = 2'd2;
  localparam logic [1:0] PAGE_SUM  = 2'd3;

  localparam int unsigned DIV_CYCLES = 14;
  localparam int unsigned BCD_CYCLES = 7;

  typedef enum logic [2:0] {
    StIdle,
    StUpdate,
    StDivide,
    StConvert,
    StLoad
  } state_e;

  typedef struct packed {
    logic [3:0] hits_t;
    logic [3:0] hits_o;
    logic [3:0] miss_t;
    logic [3:0] miss_o;
    logic [3:0] pct_h;
    logic [3:0] pct_t;
    logic [3:0] pct_o;
  } digits_t;

  function automatic logic [6:0] seg_digit(logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: add 3 to any digit >= 5, then shift in b.
  function automatic logic [11:0] dd_step(logic [11:0] bcd, logic b);
    logic [11:0] adj;
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    return {adj[10:0], b};
  endfunction

endpackage

// File: rtl/score_divider.sv
// Iterative restoring divider, one quotient bit per cycle, fixed DIV_CYCLES latency.
module score_divider
  import memory_game_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        start,
  input  logic [13:0] num,
  input  logic [7:0]  den,
  output logic        done,
  output logic [6:0]  quotient
);

  logic [13:0] quo_q, quo_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  den_q, den_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [8:0]  rem_shift;

  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    den_d     = den_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    rem_shift = {rem_q, quo_q[13]};
    done      = busy_q && (cnt_q == 4'(DIV_CYCLES - 1));

    if (clear) begin
      quo_d  = '0;
      rem_d  = '0;
      den_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (start) begin
      quo_d  = num;
      rem_d  = '0;
      den_d  = den;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Remainder always stays below den (<= 198), so 8 bits suffice.
      if (rem_shift >= {1'b0, den_q}) begin
        rem_d = 8'(rem_shift - {1'b0, den_q});
        quo_d = {quo_q[12:0], 1'b1};
      end else begin
        rem_d = rem_shift[7:0];
        quo_d = {quo_q[12:0], 1'b0};
      end
      cnt_d = cnt_q + 4'd1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // A zero divisor would produce all ones; report 0 instead.
  assign quotient = (den_q == 8'd0) ? 7'd0 : quo_q[6:0];

endmodule

// File: rtl/score_display_sequencer.sv
// Hit/miss tallies, success percentage and BCD conversion driving six
// seven-segment digits from a selectable page.
module score_display_sequencer
  import memory_game_pkg::*;
#(
  parameter int unsigned SAT_MAX = 99
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       guess_valid,
  input  logic       guess_hit,
  output logic       ready,
  input  logic [1:0] page_sel,
  output logic [6:0] hex5,
  output logic [6:0] hex4,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  localparam logic [6:0] SatMax = 7'(SAT_MAX);

  state_e            state_q, state_d;
  logic [6:0]        hits_q, hits_d;
  logic [6:0]        misses_q, misses_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        hbcd_q, hbcd_d;
  logic [7:0]        mbcd_q, mbcd_d;
  logic [11:0]       pbcd_q, pbcd_d;
  digits_t           digits_q, digits_d;
  logic [5:0][6:0]   hex_q, hex_d;
  logic [2:0]        bit_idx;

  logic              div_start;
  logic              div_done;
  logic [6:0]        pct;
  logic [13:0]       div_num;
  logic [7:0]        div_den;

  assign div_num = {7'd0, hits_q} * 14'd100;
  assign div_den = 8'(hits_q) + 8'(misses_q);

  score_divider u_divider (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (clear),
    .start    (div_start),
    .num      (div_num),
    .den      (div_den),
    .done     (div_done),
    .quotient (pct)
  );

  always_comb begin
    state_d   = state_q;
    hits_d    = hits_q;
    misses_d  = misses_q;
    cnt_d     = cnt_q;
    hbcd_d    = hbcd_q;
    mbcd_d    = mbcd_q;
    pbcd_d    = pbcd_q;
    digits_d  = digits_q;
    div_start = 1'b0;
    ready     = (state_q == StIdle);
    bit_idx   = 3'(4'(BCD_CYCLES - 1) - cnt_q);

    if (clear) begin
      state_d  = StIdle;
      hits_d   = '0;
      misses_d = '0;
      cnt_d    = '0;
      hbcd_d   = '0;
      mbcd_d   = '0;
      pbcd_d   = '0;
      digits_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (guess_valid) begin
            state_d = StUpdate;
            if (guess_hit) begin
              if (hits_q < SatMax) hits_d = hits_q + 7'd1;
            end else begin
              if (misses_q < SatMax) misses_d = misses_q + 7'd1;
            end
          end
        end
        StUpdate: begin
          div_start = 1'b1;
          state_d   = StDivide;
        end
        StDivide: begin
          if (div_done) begin
            state_d = StConvert;
            cnt_d   = '0;
            hbcd_d  = '0;
            mbcd_d  = '0;
            pbcd_d  = '0;
          end
        end
        StConvert: begin
          // MSB first: iteration k shifts in bit (6 - k) of each value.
          hbcd_d = 8'(dd_step({4'd0, hbcd_q}, hits_q[bit_idx]));
          mbcd_d = 8'(dd_step({4'd0, mbcd_q}, misses_q[bit_idx]));
          pbcd_d = dd_step(pbcd_q, pct[bit_idx]);
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'(BCD_CYCLES - 1)) state_d = StLoad;
        end
        StLoad: begin
          digits_d.hits_t = hbcd_q[7:4];
          digits_d.hits_o = hbcd_q[3:0];
          digits_d.miss_t = mbcd_q[7:4];
          digits_d.miss_o = mbcd_q[3:0];
          digits_d.pct_h  = pbcd_q[11:8];
          digits_d.pct_t  = pbcd_q[7:4];
          digits_d.pct_o  = pbcd_q[3:0];
          state_d         = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Display decodes the next shadow value so new digits land with ready.
  always_comb begin
    hex_d = {SEG_C, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0, SEG_0};
    case (page_sel)
      PAGE_HITS: hex_d = {SEG_C, SEG_BLANK, SEG_BLANK, SEG_BLANK,
                          seg_digit(digits_d.hits_t), seg_digit(digits_d.hits_o)};
      PAGE_MISS: hex_d = {SEG_E, SEG_BLANK, SEG_BLANK, SEG_BLANK,
                          seg_digit(digits_d.miss_t), seg_digit(digits_d.miss_o)};
      PAGE_PCT: begin
        hex_d[5] = SEG_P;
        hex_d[4] = SEG_BLANK;
        hex_d[3] = SEG_BLANK;
        hex_d[2] = (digits_d.pct_h == 4'd0) ? SEG_BLANK : seg_digit(digits_d.pct_h);
        hex_d[1] = (digits_d.pct_h == 4'd0 && digits_d.pct_t == 4'd0) ?
                   SEG_BLANK : seg_digit(digits_d.pct_t);
        hex_d[0] = seg_digit(digits_d.pct_o);
      end
      PAGE_SUM: begin
        hex_d[5] = seg_digit(digits_d.hits_t);
        hex_d[4] = seg_digit(digits_d.hits_o);
        hex_d[3] = seg_digit(digits_d.miss_t);
        hex_d[2] = seg_digit(digits_d.miss_o);
        // Only two digits available; 100 % clamps to 99.
        hex_d[1] = (digits_d.pct_h != 4'd0) ? SEG_9 : seg_digit(digits_d.pct_t);
        hex_d[0] = (digits_d.pct_h != 4'd0) ? SEG_9 : seg_digit(digits_d.pct_o);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      hits_q   <= '0;
      misses_q <= '0;
      cnt_q    <= '0;
      hbcd_q   <= '0;
      mbcd_q   <= '0;
      pbcd_q   <= '0;
      digits_q <= '0;
      hex_q    <= {SEG_C, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0, SEG_0};
    end else begin
      state_q  <= state_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      cnt_q    <= cnt_d;
      hbcd_q   <= hbcd_d;
      mbcd_q   <= mbcd_d;
      pbcd_q   <= pbcd_d;
      digits_q <= digits_d;
      hex_q    <= hex_d;
    end
  end

  assign hex5 = hex_q[5];
  assign hex4 = hex_q[4];
  assign hex3 = hex_q[3];
  assign hex2 = hex_q[2];
  assign hex1 = hex_q[1];
  assign hex0 = hex_q[0];

endmodule

// File: tb/tb_score_display_sequencer.sv
// Directed bench for score_display_sequencer with a scoreboard of expected snapshots.
module tb_score_display_sequencer;

  logic       clk;
  logic       resetn;
  logic       clear;
  logic       guess_valid;
  logic       guess_hit;
  logic       ready;
  logic [1:0] page_sel;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;

  score_display_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (clear),
    .guess_valid (guess_valid),
    .guess_hit   (guess_hit),
    .ready       (ready),
    .page_sel    (page_sel),
    .hex5        (hex5),
    .hex4        (hex4),
    .hex3        (hex3),
    .hex2        (hex2),
    .hex1        (hex1),
    .hex0        (hex0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h;
    int m;
    int p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mh = 0;
  int   mm = 0;
  int   mp = 0;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] LC = 7'b1000110;
  localparam logic [6:0] LE = 7'b0000110;
  localparam logic [6:0] LP = 7'b0001100;
  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  function automatic logic [41:0] exp_disp(int pg, int h, int m, int p);
    int hu, te, pp;
    hu = p / 100;
    te = (p / 10) % 10;
    pp = (p > 99) ? 99 : p;
    case (pg)
      0: return {LC, B, B, B, seg_tab[h / 10], seg_tab[h % 10]};
      1: return {LE, B, B, B, seg_tab[m / 10], seg_tab[m % 10]};
      2: return {LP, B, B, (hu == 0) ? B : seg_tab[hu],
                 (hu == 0 && te == 0) ? B : seg_tab[te], seg_tab[p % 10]};
      default: return {seg_tab[h / 10], seg_tab[h % 10], seg_tab[m / 10], seg_tab[m % 10],
                       seg_tab[pp / 10], seg_tab[pp % 10]};
    endcase
  endfunction

  function automatic logic [41:0] disp();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mh = 0;
    mm = 0;
    mp = 0;
    sb.delete();
  endtask

  task automatic set_page(input int pg);
    @(negedge clk);
    page_sel = 2'(pg);
    @(posedge clk);
    #1;
    chk($sformatf("page%0d", pg), 64'(disp()), 64'(exp_disp(pg, mh, mm, mp)));
  endtask

  // One guess; optionally inject busy-time guesses, a clear, or an async reset.
  task automatic do_guess(input bit hit, input bit inject, input int clr_at, input int rst_at);
    logic [41:0] prev;
    exp_t        e;
    int          n;
    for (int w = 0; w < 50 && !ready; w++) @(posedge clk);
    @(negedge clk);
    prev        = disp();
    guess_valid = 1'b1;
    guess_hit   = hit;
    @(posedge clk);
    #1;
    guess_valid = 1'b0;
    if (hit) mh = (mh < 99) ? mh + 1 : mh;
    else     mm = (mm < 99) ? mm + 1 : mm;
    mp = (mh + mm == 0) ? 0 : (100 * mh) / (mh + mm);
    sb.push_back('{mh, mm, mp});
    chk("ready_drop", 64'(ready), 64'(0));
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (rst_at != 0 && i == rst_at) begin
        resetn = 1'b0;
        #1;
        model_reset();
        chk("async_rst_ready", 64'(ready), 64'(1));
        chk("async_rst_disp", 64'(disp()), 64'(exp_disp(0, 0, 0, 0)));
        @(negedge clk);
        resetn = 1'b1;
        return;
      end
      if (clr_at != 0 && i == clr_at + 1) begin
        clear = 1'b0;
        model_reset();
        chk("clear_ready", 64'(ready), 64'(1));
        chk("clear_disp", 64'(disp()), 64'(exp_disp(page_sel, 0, 0, 0)));
        return;
      end
      if (clr_at != 0 && i == clr_at) clear = 1'b1;
      guess_valid = inject && (i == 5 || i == 20);
      guess_hit   = 1'b1;
      if (ready) begin
        n = i;
        break;
      end
      if (i == 22) chk("hold_snapshot", 64'(disp()), 64'(prev));
    end
    guess_valid = 1'b0;
    chk("latency", 64'(n), 64'(23));
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("result", 64'(disp()), 64'(exp_disp(page_sel, e.h, e.m, e.p)));
    end
  endtask

  task automatic do_clear(input bit with_guess);
    @(negedge clk);
    clear       = 1'b1;
    guess_valid = with_guess;
    guess_hit   = 1'b1;
    @(posedge clk);
    #1;
    clear       = 1'b0;
    guess_valid = 1'b0;
    model_reset();
    chk("clr_ready", 64'(ready), 64'(1));
    chk("clr_disp", 64'(disp()), 64'(exp_disp(page_sel, 0, 0, 0)));
    @(posedge clk);
    #1;
    chk("clr_no_accept", 64'(ready), 64'(1));
  endtask

  initial begin
    resetn      = 1'b0;
    clear       = 1'b0;
    guess_valid = 1'b0;
    guess_hit   = 1'b0;
    page_sel    = 2'd0;
    #23;
    chk("reset_ready", 64'(ready), 64'(1));
    chk("reset_disp", 64'(disp()), 64'(exp_disp(0, 0, 0, 0)));
    @(negedge clk);
    resetn = 1'b1;
    set_page(0);
    set_page(2);

    // 3 hits + 1 miss -> 75 %
    do_guess(1, 0, 0, 0);
    do_guess(1, 0, 0, 0);
    do_guess(1, 0, 0, 0);
    do_guess(0, 0, 0, 0);
    set_page(0);
    set_page(1);
    set_page(3);

    // 1 hit + 2 misses -> 33 %
    set_page(2);
    do_clear(0);
    do_guess(1, 0, 0, 0);
    do_guess(0, 0, 0, 0);
    do_guess(0, 0, 0, 0);

    // 5 hits with busy-time guesses ignored -> 100 %
    do_clear(0);
    for (int k = 0; k < 5; k++) do_guess(1, 1, 0, 0);
    set_page(3);
    set_page(2);

    // Saturation
    do_clear(0);
    set_page(0);
    for (int k = 0; k < 101; k++) do_guess(1, 0, 0, 0);
    set_page(2);
    set_page(3);

    // Clear during DIVIDE, clear together with a guess, reset during CONVERT
    set_page(1);
    do_guess(0, 0, 8, 0);
    do_guess(0, 0, 0, 0);
    do_clear(1);
    set_page(0);
    do_guess(1, 0, 0, 0);
    do_guess(1, 0, 0, 18);
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(ready), 64'(1));
    do_guess(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
